// File: rtl/image_mirror_pkg.sv
// Shared stream definitions for the image_mirror stage: data-type codes and a
// classifier for the words that belong to the row being buffered.
package image_mirror_pkg;

    localparam int unsigned DTYPE_WIDTH = 3;

    typedef logic [DTYPE_WIDTH-1:0] dtype_t;

    localparam dtype_t FRAME_START = 3'd1;
    localparam dtype_t FRAME_END   = 3'd2;
    localparam dtype_t ROW_START   = 3'd3;
    localparam dtype_t ROW_END     = 3'd4;
    localparam dtype_t PIXEL       = 3'd5;

    // Row words are consumed by the line buffer and never passed straight through.
    function automatic logic is_row_word(input dtype_t t);
        return (t == ROW_START) || (t == ROW_END) || (t == PIXEL);
    endfunction

endpackage

// File: rtl/image_mirror_ram.sv
// Simple dual-port line RAM for image_mirror: one synchronous write port and one
// synchronous read port with single-cycle latency. The address MSB selects the bank.
module image_mirror_ram #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    // Sized by address width so the bank bit maps cleanly for any MAX_WIDTH.
    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    // Write port and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/image_mirror.sv
// Horizontal mirror stage: buffers each row in a ping-pong line RAM and replays it
// reversed (mode=1) or forward (mode=0) one row later.
// Optional statistics outputs are enabled with the IMAGE_MIRROR_STATS_EN macro.
module image_mirror
    import image_mirror_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_WIDTH  = 2048,
    parameter int unsigned ADDR_WIDTH = 11
) (
    input  logic                   img_clk,
    input  logic                   reset,
    input  logic                   mirror_en,
    input  logic                   dvi,
    input  logic [DTYPE_WIDTH-1:0] dtypei,
    input  logic [DATA_WIDTH-1:0]  datai,
    output logic                   dvo,
    output logic [DTYPE_WIDTH-1:0] dtypeo,
    output logic [DATA_WIDTH-1:0]  datao,
    output logic                   busy,
`ifdef IMAGE_MIRROR_STATS_EN
    output logic [ADDR_WIDTH:0]    last_row_width,
    output logic [15:0]            row_count,
`endif
    output logic                   overflow
);

    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] MaxCnt = CW'(MAX_WIDTH);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRs    = 3'd1;
    localparam logic [2:0] StDrain = 3'd2;
    localparam logic [2:0] StRe    = 3'd3;
    localparam logic [2:0] StFlush = 3'd4;

    logic [CW-1:0] waddr_q, waddr_d;
    logic          wbank_q, wbank_d;
    logic          mode_q, mode_d;
    logic          overflow_q, overflow_d;
    logic          fs_set, fe_set, wr_en;

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         rlen_q, rlen_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                  rbank_q, rbank_d;
    logic                  rdir_q, rdir_d;
    logic                  fs_pend_q, fs_pend_d;
    logic                  fe_pend_q, fe_pend_d;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] rd_lo;
    logic                  rd_bank;
    logic [DATA_WIDTH-1:0] rdata;

    logic                   dvo_d;
    logic [DTYPE_WIDTH-1:0] dtypeo_d;
    logic [DATA_WIDTH-1:0]  datao_d;

    assign accept   = dvi && (dtypei == ROW_END) && (state_q == StIdle);
    assign wr_en    = dvi && (dtypei == PIXEL) && (waddr_q != MaxCnt);
    assign busy     = (state_q != StIdle);
    assign overflow = overflow_q;

    image_mirror_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH + 1)
    ) u_ram (
        .clk   (img_clk),
        .we    (wr_en),
        .waddr ({wbank_q, waddr_q[ADDR_WIDTH-1:0]}),
        .wdata (datai),
        .raddr ({rd_bank, rd_lo}),
        .rdata (rdata)
    );

    // Write side: address counter, bank select, frame mode and overflow flag.
    always_comb begin
        waddr_d    = waddr_q;
        wbank_d    = wbank_q;
        mode_d     = mode_q;
        overflow_d = overflow_q;
        fs_set     = 1'b0;
        fe_set     = 1'b0;
        if (dvi) begin
            case (dtypei)
                ROW_START: waddr_d = '0;
                PIXEL: begin
                    if (waddr_q == MaxCnt) overflow_d = 1'b1;
                    else                   waddr_d = waddr_q + 1'b1;
                end
                ROW_END: begin
                    waddr_d = '0;
                    if (state_q == StIdle) wbank_d = ~wbank_q;
                    else                   overflow_d = 1'b1;
                end
                FRAME_START: begin
                    mode_d     = mirror_en;
                    overflow_d = 1'b0;
                    fs_set     = (state_q != StIdle);
                end
                FRAME_END: fe_set = (state_q != StIdle);
                default: ;
            endcase
        end
    end

    // Write-side state registers.
    always_ff @(posedge img_clk) begin
        if (reset) begin
            waddr_q    <= '0;
            wbank_q    <= 1'b0;
            mode_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            waddr_q    <= waddr_d;
            wbank_q    <= wbank_d;
            mode_q     <= mode_d;
            overflow_q <= overflow_d;
        end
    end

    // Read FSM next state. The first RAM read is issued in the accepting cycle so that
    // pixel data is ready to be registered onto the output on the first DRAIN cycle.
    always_comb begin
        state_d   = state_q;
        rlen_d    = rlen_q;
        cnt_d     = cnt_q;
        rbank_d   = rbank_q;
        rdir_d    = rdir_q;
        fs_pend_d = fs_pend_q | fs_set;
        fe_pend_d = fe_pend_q | fe_set;
        rd_lo     = raddr_q;
        rd_bank   = rbank_q;
        raddr_d   = rdir_q ? raddr_q - 1'b1 : raddr_q + 1'b1;
        case (state_q)
            StIdle: begin
                raddr_d = raddr_q;
                if (accept) begin
                    state_d = StRs;
                    rlen_d  = waddr_q;
                    rbank_d = wbank_q;
                    rdir_d  = mode_q;
                    rd_bank = wbank_q;
                    rd_lo   = mode_q ? ADDR_WIDTH'(waddr_q - 1'b1) : '0;
                    raddr_d = mode_q ? rd_lo - 1'b1 : rd_lo + 1'b1;
                end
            end
            StRs: begin
                state_d = (rlen_q == '0) ? StRe : StDrain;
                cnt_d   = CW'(1);
            end
            StDrain: begin
                if (cnt_q == rlen_q) state_d = StRe;
                else                 cnt_d = cnt_q + 1'b1;
            end
            StRe: state_d = (fs_pend_d || fe_pend_d) ? StFlush : StIdle;
            StFlush: begin
                // FRAME_END goes out before FRAME_START; a word arriving now re-arms its flag.
                if (fe_pend_q) fe_pend_d = fe_set;
                else           fs_pend_d = fs_set;
                state_d = (fs_pend_d || fe_pend_d) ? StFlush : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Read FSM registers.
    always_ff @(posedge img_clk) begin
        if (reset) begin
            state_q   <= StIdle;
            rlen_q    <= '0;
            cnt_q     <= '0;
            raddr_q   <= '0;
            rbank_q   <= 1'b0;
            rdir_q    <= 1'b0;
            fs_pend_q <= 1'b0;
            fe_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rlen_q    <= rlen_d;
            cnt_q     <= cnt_d;
            raddr_q   <= raddr_d;
            rbank_q   <= rbank_d;
            rdir_q    <= rdir_d;
            fs_pend_q <= fs_pend_d;
            fe_pend_q <= fe_pend_d;
        end
    end

    // Output word for the next cycle, selected by the state the FSM is entering.
    always_comb begin
        dvo_d    = 1'b0;
        dtypeo_d = '0;
        datao_d  = '0;
        case (state_d)
            StIdle: begin
                if (state_q == StIdle && dvi && !is_row_word(dtypei)) begin
                    dvo_d    = 1'b1;
                    dtypeo_d = dtypei;
                    datao_d  = datai;
                end
            end
            StRs: begin
                dvo_d    = 1'b1;
                dtypeo_d = ROW_START;
            end
            StDrain: begin
                dvo_d    = 1'b1;
                dtypeo_d = PIXEL;
                datao_d  = rdata;
            end
            StRe: begin
                dvo_d    = 1'b1;
                dtypeo_d = ROW_END;
            end
            StFlush: begin
                dvo_d    = 1'b1;
                dtypeo_d = fe_pend_d ? FRAME_END : FRAME_START;
            end
            default: ;
        endcase
    end

    // Registered output stage.
    always_ff @(posedge img_clk) begin
        if (reset) begin
            dvo    <= 1'b0;
            dtypeo <= '0;
            datao  <= '0;
        end else begin
            dvo    <= dvo_d;
            dtypeo <= dtypeo_d;
            datao  <= datao_d;
        end
    end

`ifdef IMAGE_MIRROR_STATS_EN
    logic [ADDR_WIDTH:0] last_row_width_q;
    logic [15:0]         row_count_q;

    // Width of the last accepted row and saturating accepted-row count per frame.
    always_ff @(posedge img_clk) begin
        if (reset) begin
            last_row_width_q <= '0;
            row_count_q      <= '0;
        end else if (dvi && dtypei == FRAME_START) begin
            row_count_q <= '0;
        end else if (accept) begin
            last_row_width_q <= waddr_q;
            if (row_count_q != 16'hFFFF) row_count_q <= row_count_q + 1'b1;
        end
    end

    assign last_row_width = last_row_width_q;
    assign row_count      = row_count_q;
`else
    // Statistics disabled: no extra state.
`endif

endmodule

// File: tb/tb_image_mirror.sv
// Directed self-checking bench for image_mirror (MAX_WIDTH=8 build).
module tb_image_mirror;
    import image_mirror_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned MW = 8;
    localparam int unsigned AW = 3;

    logic          img_clk = 1'b0;
    logic          reset = 1'b1;
    logic          mirror_en = 1'b0;
    logic          dvi = 1'b0;
    dtype_t        dtypei = '0;
    logic [DW-1:0] datai = '0;
    logic          dvo;
    dtype_t        dtypeo;
    logic [DW-1:0] datao;
    logic          busy;
    logic          overflow;
`ifdef IMAGE_MIRROR_STATS_EN
    logic [AW:0]   last_row_width;
    logic [15:0]   row_count;
`endif

    image_mirror #(
        .DATA_WIDTH (DW),
        .MAX_WIDTH  (MW),
        .ADDR_WIDTH (AW)
    ) dut (
        .img_clk        (img_clk),
        .reset          (reset),
        .mirror_en      (mirror_en),
        .dvi            (dvi),
        .dtypei         (dtypei),
        .datai          (datai),
        .dvo            (dvo),
        .dtypeo         (dtypeo),
        .datao          (datao),
        .busy           (busy),
`ifdef IMAGE_MIRROR_STATS_EN
        .last_row_width (last_row_width),
        .row_count      (row_count),
`endif
        .overflow       (overflow)
    );

    always #5 img_clk = ~img_clk;

    int cyc = 0;
    always @(posedge img_clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        dtype_t        t;
        logic [DW-1:0] d;
    } word_t;

    word_t         got[$];
    dtype_t        exp_t[$];
    logic [DW-1:0] exp_d[$];
    int            n_cmp = 0;
    int            n_fail = 0;

    always @(negedge img_clk) begin
        if (!reset && dvo) got.push_back('{cyc, dtypeo, datao});
    end

    function automatic void ex(input dtype_t t, input logic [DW-1:0] d);
        exp_t.push_back(t);
        exp_d.push_back(d);
    endfunction

    function automatic void clear_all();
        got.delete();
        exp_t.delete();
        exp_d.delete();
    endfunction

    // Drive one word for one cycle; entered and left at posedge+1.
    task automatic send(input dtype_t t, input logic [DW-1:0] d, output int c);
        dvi = 1'b1;
        dtypei = t;
        datai = d;
        c = cyc;
        @(posedge img_clk);
        #1;
        dvi = 1'b0;
        dtypei = '0;
        datai = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge img_clk);
            #1;
        end
    endtask

    task automatic send_row(input int base, input int n, output int re_c);
        int c;
        send(ROW_START, '0, c);
        for (int i = 0; i < n; i++) send(PIXEL, DW'(base + i), c);
        send(ROW_END, '0, re_c);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge img_clk);
        @(negedge img_clk);
        n_cmp++;
        if (dvo !== 1'b0 || dtypeo !== '0 || datao !== '0) begin
            n_fail++;
            $display("FAIL reset_out: dvo=%b dtypeo=%0d datao=%0h, expected 0/0/0", dvo, dtypeo, datao);
        end
        n_cmp++;
        if (busy !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b overflow=%b, expected 0/0", busy, overflow);
        end
        @(posedge img_clk);
        #1;
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_mirror_on();
        int fs_c, re1, re2, c;
        clear_all();
        mirror_en = 1'b1;
        send(FRAME_START, '0, fs_c);
        send_row(1, 4, re1);
        idle(4);
        send_row(5, 4, re2);
        idle(4);
        send(FRAME_END, '0, c);
        idle(15);
        ex(FRAME_START, 0);
        ex(ROW_START, 0); ex(PIXEL, 4); ex(PIXEL, 3); ex(PIXEL, 2); ex(PIXEL, 1); ex(ROW_END, 0);
        ex(ROW_START, 0); ex(PIXEL, 8); ex(PIXEL, 7); ex(PIXEL, 6); ex(PIXEL, 5); ex(ROW_END, 0);
        ex(FRAME_END, 0);
        n_cmp++;
        if (got.size() != exp_t.size()) begin
            n_fail++;
            $display("FAIL mirror_on_count: got %0d words, expected %0d", got.size(), exp_t.size());
        end
        for (int i = 0; i < got.size() && i < exp_t.size(); i++) begin
            n_cmp++;
            if (got[i].t !== exp_t[i] || got[i].d !== exp_d[i]) begin
                n_fail++;
                $display("FAIL mirror_on_word%0d: got type %0d data %0d, expected type %0d data %0d",
                         i, got[i].t, got[i].d, exp_t[i], exp_d[i]);
            end
        end
        if (got.size() >= 2) begin
            n_cmp++;
            if (got[0].cyc !== fs_c + 1) begin
                n_fail++;
                $display("FAIL mirror_on_fs_lat: at cycle %0d, expected %0d", got[0].cyc, fs_c + 1);
            end
            n_cmp++;
            if (got[1].cyc !== re1 + 1) begin
                n_fail++;
                $display("FAIL mirror_on_rs_lat: at cycle %0d, expected %0d", got[1].cyc, re1 + 1);
            end
        end
        n_cmp++;
        if (busy !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL mirror_on_flags: busy=%b overflow=%b, expected 0/0", busy, overflow);
        end
    endtask

    task automatic test_mirror_off();
        int c, re1, re2;
        clear_all();
        mirror_en = 1'b0;
        send(FRAME_START, '0, c);
        send_row(1, 4, re1);
        send(3'd6, 16'hDEAD, c);  // arrives while busy: dropped
        idle(10);
        send(3'd6, 16'h1234, c);  // idle: passed through
        mirror_en = 1'b1;         // ignored until next FRAME_START
        idle(2);
        send_row(5, 4, re2);
        idle(10);
        send(FRAME_END, '0, c);
        idle(4);
        ex(FRAME_START, 0);
        ex(ROW_START, 0); ex(PIXEL, 1); ex(PIXEL, 2); ex(PIXEL, 3); ex(PIXEL, 4); ex(ROW_END, 0);
        ex(3'd6, 16'h1234);
        ex(ROW_START, 0); ex(PIXEL, 5); ex(PIXEL, 6); ex(PIXEL, 7); ex(PIXEL, 8); ex(ROW_END, 0);
        ex(FRAME_END, 0);
        n_cmp++;
        if (got.size() != exp_t.size()) begin
            n_fail++;
            $display("FAIL mirror_off_count: got %0d words, expected %0d", got.size(), exp_t.size());
        end
        for (int i = 0; i < got.size() && i < exp_t.size(); i++) begin
            n_cmp++;
            if (got[i].t !== exp_t[i] || got[i].d !== exp_d[i]) begin
                n_fail++;
                $display("FAIL mirror_off_word%0d: got type %0d data %0h, expected type %0d data %0h",
                         i, got[i].t, got[i].d, exp_t[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c, re;
        clear_all();
        mirror_en = 1'b1;
        send(FRAME_START, '0, c);
        send_row(1, 4, re);
        send(FRAME_END, '0, c);
        send(FRAME_START, '0, c);
        idle(12);
        ex(FRAME_START, 0);
        ex(ROW_START, 0); ex(PIXEL, 4); ex(PIXEL, 3); ex(PIXEL, 2); ex(PIXEL, 1); ex(ROW_END, 0);
        ex(FRAME_END, 0); ex(FRAME_START, 0);
        n_cmp++;
        if (got.size() != exp_t.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d words, expected %0d", got.size(), exp_t.size());
        end
        for (int i = 0; i < got.size() && i < exp_t.size(); i++) begin
            n_cmp++;
            if (got[i].t !== exp_t[i] || got[i].d !== exp_d[i]) begin
                n_fail++;
                $display("FAIL b2b_word%0d: got type %0d data %0d, expected type %0d data %0d",
                         i, got[i].t, got[i].d, exp_t[i], exp_d[i]);
            end
        end
        if (got.size() == 9) begin
            n_cmp++;
            if (got[6].cyc !== re + 6 || got[7].cyc !== re + 7 || got[8].cyc !== re + 8) begin
                n_fail++;
                $display("FAIL b2b_timing: RE/FE/FS at %0d/%0d/%0d, expected %0d/%0d/%0d",
                         got[6].cyc, got[7].cyc, got[8].cyc, re + 6, re + 7, re + 8);
            end
        end
    endtask

    task automatic test_overflow();
        int c, re;
        clear_all();
        mirror_en = 1'b1;
        send(FRAME_START, '0, c);
        send_row(1, 10, re);
        idle(20);
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: overflow=%b, expected 1", overflow);
        end
        send(FRAME_START, '0, c);
        @(negedge img_clk);
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: overflow=%b, expected 0", overflow);
        end
        idle(3);
        ex(FRAME_START, 0);
        ex(ROW_START, 0);
        for (int i = 8; i >= 1; i--) ex(PIXEL, DW'(i));
        ex(ROW_END, 0);
        ex(FRAME_START, 0);
        n_cmp++;
        if (got.size() != exp_t.size()) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d words, expected %0d", got.size(), exp_t.size());
        end
        for (int i = 0; i < got.size() && i < exp_t.size(); i++) begin
            n_cmp++;
            if (got[i].t !== exp_t[i] || got[i].d !== exp_d[i]) begin
                n_fail++;
                $display("FAIL ovf_word%0d: got type %0d data %0d, expected type %0d data %0d",
                         i, got[i].t, got[i].d, exp_t[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_busy_row_end();
        int c, re, re2;
        clear_all();
        mirror_en = 1'b1;
        send(FRAME_START, '0, c);
        send_row(1, 4, re);
        send_row(9, 1, re2);  // its ROW_END lands during DRAIN
        @(negedge img_clk);
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_re_ovf: overflow=%b, expected 1", overflow);
        end
        @(posedge img_clk);
        #1;
        idle(12);
        send(FRAME_START, '0, c);
        send_row(11, 2, re);
        idle(10);
        ex(FRAME_START, 0);
        ex(ROW_START, 0); ex(PIXEL, 4); ex(PIXEL, 3); ex(PIXEL, 2); ex(PIXEL, 1); ex(ROW_END, 0);
        ex(FRAME_START, 0);
        ex(ROW_START, 0); ex(PIXEL, 12); ex(PIXEL, 11); ex(ROW_END, 0);
        n_cmp++;
        if (got.size() != exp_t.size()) begin
            n_fail++;
            $display("FAIL busy_re_count: got %0d words, expected %0d", got.size(), exp_t.size());
        end
        for (int i = 0; i < got.size() && i < exp_t.size(); i++) begin
            n_cmp++;
            if (got[i].t !== exp_t[i] || got[i].d !== exp_d[i]) begin
                n_fail++;
                $display("FAIL busy_re_word%0d: got type %0d data %0d, expected type %0d data %0d",
                         i, got[i].t, got[i].d, exp_t[i], exp_d[i]);
            end
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_re_ovf_clr: overflow=%b, expected 0", overflow);
        end
    endtask

    task automatic test_reset_mid_row();
        int c, re, re0;
        clear_all();
        mirror_en = 1'b1;
        send(FRAME_START, '0, c);
        send_row(1, 4, re);
        idle(2);
        @(negedge img_clk);
        n_cmp++;
        if (busy !== 1'b1 || dvo !== 1'b1 || dtypeo !== PIXEL || datao !== 16'd3) begin
            n_fail++;
            $display("FAIL rst_pre: busy=%b dvo=%b type=%0d data=%0d, expected 1/1/%0d/3",
                     busy, dvo, dtypeo, datao, PIXEL);
        end
        reset = 1'b1;
        @(negedge img_clk);
        n_cmp++;
        if (dvo !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: dvo=%b busy=%b, expected 0/0", dvo, busy);
        end
        reset = 1'b0;
        @(posedge img_clk);
        #1;
        clear_all();
        send(FRAME_START, '0, c);
        send(ROW_START, '0, c);
        send(ROW_END, '0, re0);
        idle(4);
        send_row(5, 2, re);
        idle(4);
        send(FRAME_END, '0, c);
        idle(4);
        ex(FRAME_START, 0);
        ex(ROW_START, 0); ex(ROW_END, 0);
        ex(ROW_START, 0); ex(PIXEL, 6); ex(PIXEL, 5); ex(ROW_END, 0);
        ex(FRAME_END, 0);
        n_cmp++;
        if (got.size() != exp_t.size()) begin
            n_fail++;
            $display("FAIL rst_after_count: got %0d words, expected %0d", got.size(), exp_t.size());
        end
        for (int i = 0; i < got.size() && i < exp_t.size(); i++) begin
            n_cmp++;
            if (got[i].t !== exp_t[i] || got[i].d !== exp_d[i]) begin
                n_fail++;
                $display("FAIL rst_after_word%0d: got type %0d data %0d, expected type %0d data %0d",
                         i, got[i].t, got[i].d, exp_t[i], exp_d[i]);
            end
        end
        if (got.size() >= 3) begin
            n_cmp++;
            if (got[1].cyc !== re0 + 1 || got[2].cyc !== re0 + 2) begin
                n_fail++;
                $display("FAIL zero_row_timing: RS/RE at %0d/%0d, expected %0d/%0d",
                         got[1].cyc, got[2].cyc, re0 + 1, re0 + 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mirror_on();
        test_mirror_off();
        test_back_to_back();
        test_overflow();
        test_busy_row_end();
        test_reset_mid_row();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
